// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler between Decode and the Branch (lane 0) and
// Memory (lane 1) pipelines. It holds up to DEPTH decoded instructions and
// issues the oldest one or two each cycle. Pairing is refused on intra-pair
// RAW/WAW, a branch in the older slot, or a pipe-class conflict. Issue is
// blocked while a load in Ex feeds the oldest entry.
module dual_issue_scheduler #(
  parameter int WIDTH     = 32,
  parameter int RS        = 5,
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 96
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                in_valid,
  input  logic [1:0][1:0]           in_class,
  input  logic [1:0][RS-1:0]        in_rs1,
  input  logic [1:0][RS-1:0]        in_rs2,
  input  logic [1:0][RS-1:0]        in_rd,
  input  logic [1:0]                in_use_rs1,
  input  logic [1:0]                in_use_rs2,
  input  logic [1:0]                in_we,
  input  logic [1:0][PAYLOAD_W-1:0] in_payload,
  output logic                      in_ready,
  input  logic                      ex_load_valid,
  input  logic [RS-1:0]             ex_load_rd,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic                      br_valid,
  output logic [RS-1:0]             br_rd,
  output logic                      br_we,
  output logic [PAYLOAD_W-1:0]      br_payload,
  output logic                      mem_valid,
  output logic [RS-1:0]             mem_rd,
  output logic                      mem_we,
  output logic [PAYLOAD_W-1:0]      mem_payload,
  output logic                      stall_dec,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Elaboration-time guards on the parameter set.
  if (PAYLOAD_W < WIDTH) begin : g_bad_payload
    $error("payload must be at least WIDTH bits to carry the PC");
  end
  if ((DEPTH < 2) || ((1 << PW) != DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_BR  = 2'b01,
    CLS_MEM = 2'b10
  } cls_e;

  typedef struct packed {
    cls_e                 cls;
    logic [RS-1:0]        rs1;
    logic [RS-1:0]        rs2;
    logic [RS-1:0]        rd;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 we;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  // Class encoding 2'b11 is folded into ALU at enqueue time.
  function automatic cls_e norm_class(input logic [1:0] c);
    case (c)
      2'b01:   return CLS_BR;
      2'b10:   return CLS_MEM;
      default: return CLS_ALU;
    endcase
  endfunction

  // Load-use hazard: the load in Ex writes a register this entry reads.
  function automatic logic load_hz(input entry_t e, input logic lv,
                                   input logic [RS-1:0] lrd);
    return lv && (lrd != '0) &&
           ((e.use_rs1 && (e.rs1 == lrd)) || (e.use_rs2 && (e.rs2 == lrd)));
  endfunction

  entry_t               queue_q [DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 br_valid_q, br_valid_d, mem_valid_q, mem_valid_d;
  logic [RS-1:0]        br_rd_q, br_rd_d, mem_rd_q, mem_rd_d;
  logic                 br_we_q, br_we_d, mem_we_q, mem_we_d;
  logic [PAYLOAD_W-1:0] br_payload_q, br_payload_d;
  logic [PAYLOAD_W-1:0] mem_payload_q, mem_payload_d;

  entry_t               h0, h1;
  entry_t [1:0]         in_entry;
  logic                 issue0, issue1;
  logic                 h0_to_mem, h1_to_mem, h1_pipe_free;
  logic                 raw, waw;
  logic [1:0]           enq, deq;

  // Admission depends only on the registered count, never on this cycle's dequeue.
  assign in_ready  = rst && (count_q <= CW'(DEPTH - 2));
  assign stall_dec = ~in_ready;
  assign occupancy = count_q;

  // Pack the two Decode slots into queue entries.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      in_entry[s].cls     = norm_class(in_class[s]);
      in_entry[s].rs1     = in_rs1[s];
      in_entry[s].rs2     = in_rs2[s];
      in_entry[s].rd      = in_rd[s];
      in_entry[s].use_rs1 = in_use_rs1[s];
      in_entry[s].use_rs2 = in_use_rs2[s];
      in_entry[s].we      = in_we[s];
      in_entry[s].payload = in_payload[s];
    end
  end

  // Issue selection and steering for the two oldest entries.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    h0           = queue_q[head_q];
    h1           = queue_q[head_q + PW'(1)];
    h0_to_mem    = (h0.cls == CLS_MEM);
    h1_to_mem    = 1'b0;
    h1_pipe_free = 1'b0;
    case (h1.cls)
      CLS_BR: begin
        h1_pipe_free = h0_to_mem;
        h1_to_mem    = 1'b0;
      end
      CLS_MEM: begin
        h1_pipe_free = !h0_to_mem;
        h1_to_mem    = 1'b1;
      end
      default: begin
        h1_pipe_free = 1'b1;
        h1_to_mem    = !h0_to_mem;
      end
    endcase
    raw = h0.we && (h0.rd != '0) &&
          ((h1.use_rs1 && (h1.rs1 == h0.rd)) || (h1.use_rs2 && (h1.rs2 == h0.rd)));
    waw = h0.we && h1.we && (h0.rd != '0) && (h0.rd == h1.rd);
    issue0 = (count_q >= CW'(1)) && out_ready &&
             !load_hz(h0, ex_load_valid, ex_load_rd);
    issue1 = issue0 && (count_q >= CW'(2)) &&
             !load_hz(h1, ex_load_valid, ex_load_rd) &&
             (h0.cls != CLS_BR) && !raw && !waw && h1_pipe_free;
  end

  // Queue pointer and count next-state; flush empties the queue and drops new entries.
  always_comb begin
    enq = 2'd0;
    if (in_ready && in_valid[0]) enq = in_valid[1] ? 2'd2 : 2'd1;
    deq = {1'b0, issue0} + {1'b0, issue1};
    if (flush) begin
      count_d = '0;
      head_d  = tail_q;
      tail_d  = tail_q;
    end else begin
      count_d = count_q + CW'(enq) - CW'(deq);
      head_d  = head_q + PW'(deq);
      tail_d  = tail_q + PW'(enq);
    end
  end

  // Issue register next-state; an unused pipe drops valid and keeps its old fields.
  always_comb begin
    br_valid_d    = br_valid_q;
    br_rd_d       = br_rd_q;
    br_we_d       = br_we_q;
    br_payload_d  = br_payload_q;
    mem_valid_d   = mem_valid_q;
    mem_rd_d      = mem_rd_q;
    mem_we_d      = mem_we_q;
    mem_payload_d = mem_payload_q;
    if (flush) begin
      br_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
    end else if (out_ready) begin
      br_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      if (issue0) begin
        if (h0_to_mem) begin
          mem_valid_d = 1'b1;  mem_rd_d = h0.rd;  mem_we_d = h0.we;
          mem_payload_d = h0.payload;
        end else begin
          br_valid_d = 1'b1;   br_rd_d = h0.rd;   br_we_d = h0.we;
          br_payload_d = h0.payload;
        end
      end
      if (issue1) begin
        if (h1_to_mem) begin
          mem_valid_d = 1'b1;  mem_rd_d = h1.rd;  mem_we_d = h1.we;
          mem_payload_d = h1.payload;
        end else begin
          br_valid_d = 1'b1;   br_rd_d = h1.rd;   br_we_d = h1.we;
          br_payload_d = h1.payload;
        end
      end
    end
  end

  // Control state and issue registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      br_valid_q    <= 1'b0;
      br_rd_q       <= '0;
      br_we_q       <= 1'b0;
      br_payload_q  <= '0;
      mem_valid_q   <= 1'b0;
      mem_rd_q      <= '0;
      mem_we_q      <= 1'b0;
      mem_payload_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      br_valid_q    <= br_valid_d;
      br_rd_q       <= br_rd_d;
      br_we_q       <= br_we_d;
      br_payload_q  <= br_payload_d;
      mem_valid_q   <= mem_valid_d;
      mem_rd_q      <= mem_rd_d;
      mem_we_q      <= mem_we_d;
      mem_payload_q <= mem_payload_d;
    end
  end

  // Queue storage: slot0 is written at tail, slot1 follows it.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; count/head/tail decide which entries are live.
    if (rst && !flush && (enq != 2'd0)) begin
      queue_q[tail_q] <= in_entry[0];
      if (enq == 2'd2) queue_q[tail_q + PW'(1)] <= in_entry[1];
    end
  end

  assign br_valid    = br_valid_q;
  assign br_rd       = br_rd_q;
  assign br_we       = br_we_q;
  assign br_payload  = br_payload_q;
  assign mem_valid   = mem_valid_q;
  assign mem_rd      = mem_rd_q;
  assign mem_we      = mem_we_q;
  assign mem_payload = mem_payload_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: pairing, hazards, steering, backpressure, flush, reset.
module tb_dual_issue_scheduler;

  localparam int RS = 5;
  localparam int PW = 96;

  localparam logic [1:0] C_ALU = 2'b00;
  localparam logic [1:0] C_BR  = 2'b01;
  localparam logic [1:0] C_MEM = 2'b10;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          in_valid;
  logic [1:0][1:0]     in_class;
  logic [1:0][RS-1:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]          in_use_rs1, in_use_rs2, in_we;
  logic [1:0][PW-1:0]  in_payload;
  logic                in_ready;
  logic                ex_load_valid;
  logic [RS-1:0]       ex_load_rd;
  logic                out_ready;
  logic                flush;
  logic                br_valid, br_we, mem_valid, mem_we;
  logic [RS-1:0]       br_rd, mem_rd;
  logic [PW-1:0]       br_payload, mem_payload;
  logic                stall_dec;
  logic [2:0]          occupancy;

  int total = 0;
  int bad   = 0;

  dual_issue_scheduler #(.WIDTH(32), .RS(RS), .DEPTH(4), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_class(in_class),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_we(in_we),
    .in_payload(in_payload), .in_ready(in_ready),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_ready(out_ready), .flush(flush),
    .br_valid(br_valid), .br_rd(br_rd), .br_we(br_we), .br_payload(br_payload),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_we(mem_we), .mem_payload(mem_payload),
    .stall_dec(stall_dec), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_valid   = 2'b00;
    in_class   = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_rd      = '0;
    in_use_rs1 = '0;
    in_use_rs2 = '0;
    in_we      = '0;
    in_payload = '0;
  endtask

  task automatic set_slot(input int s, input logic [1:0] c, input logic [RS-1:0] rs1,
                          input logic [RS-1:0] rs2, input logic [RS-1:0] rd,
                          input logic u1, input logic u2, input logic we,
                          input logic [PW-1:0] pl);
    in_class[s]   = c;
    in_rs1[s]     = rs1;
    in_rs2[s]     = rs2;
    in_rd[s]      = rd;
    in_use_rs1[s] = u1;
    in_use_rs2[s] = u2;
    in_we[s]      = we;
    in_payload[s] = pl;
  endtask

  task automatic test_reset;
    rst = 1'b0; out_ready = 1'b1; flush = 1'b0;
    ex_load_valid = 1'b0; ex_load_rd = '0;
    clear_inputs();
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready got=%0b exp=0", in_ready); end
    total++; if (stall_dec !== 1'b1) begin bad++; $display("FAIL reset stall_dec got=%0b exp=1", stall_dec); end
    total++; if (br_valid !== 1'b0 || mem_valid !== 1'b0) begin bad++; $display("FAIL reset valids got=%0b%0b exp=00", br_valid, mem_valid); end
    total++; if (br_rd !== 5'd0 || mem_rd !== 5'd0 || br_we !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset rd_we got=%0d/%0d/%0b/%0b exp=0", br_rd, mem_rd, br_we, mem_we); end
    total++; if (br_payload !== '0 || mem_payload !== '0) begin bad++; $display("FAIL reset payload got=%0h/%0h exp=0", br_payload, mem_payload); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset occupancy got=%0d exp=0", occupancy); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release in_ready got=%0b exp=1", in_ready); end
    total++; if (stall_dec !== 1'b0) begin bad++; $display("FAIL reset_release stall_dec got=%0b exp=0", stall_dec); end
  endtask

  task automatic test_basic;
    // ALU x1 <- x2+x3 ; lw x4,0(x5)
    set_slot(0, C_ALU, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 96'hA1);
    set_slot(1, C_MEM, 5'd5, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 96'hB2);
    in_valid = 2'b11;
    tick(); clear_inputs();
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL basic_enq occupancy got=%0d exp=2", occupancy); end
    total++; if (br_valid !== 1'b0) begin bad++; $display("FAIL basic_latency br_valid got=%0b exp=0", br_valid); end
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd1 || br_payload !== 96'hA1) begin bad++; $display("FAIL basic br got=v%0b rd%0d pl%0h exp=v1 rd1 plA1", br_valid, br_rd, br_payload); end
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd4 || mem_payload !== 96'hB2) begin bad++; $display("FAIL basic mem got=v%0b rd%0d pl%0h exp=v1 rd4 plB2", mem_valid, mem_rd, mem_payload); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL basic_drain occupancy got=%0d exp=0", occupancy); end
    tick();
    total++; if (br_valid !== 1'b0 || br_payload !== 96'hA1) begin bad++; $display("FAIL basic_hold br got=v%0b pl%0h exp=v0 plA1", br_valid, br_payload); end
    // 2'b10 is illegal and must enqueue nothing.
    set_slot(1, C_ALU, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 96'hEE);
    in_valid = 2'b10;
    tick(); clear_inputs();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL illegal_valid occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_raw;
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 96'hC6);
    set_slot(1, C_ALU, 5'd6, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 96'hC7);
    in_valid = 2'b11;
    tick(); clear_inputs();
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd6 || mem_valid !== 1'b0) begin bad++; $display("FAIL raw_k got=bv%0b rd%0d mv%0b exp=bv1 rd6 mv0", br_valid, br_rd, mem_valid); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL raw_k occupancy got=%0d exp=1", occupancy); end
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd7 || br_payload !== 96'hC7 || mem_valid !== 1'b0) begin bad++; $display("FAIL raw_k1 got=bv%0b rd%0d pl%0h mv%0b exp=bv1 rd7 plC7 mv0", br_valid, br_rd, br_payload, mem_valid); end
  endtask

  task automatic test_waw;
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 96'hD8);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 96'hE8);
    in_valid = 2'b11;
    tick(); clear_inputs();
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd8 || mem_valid !== 1'b0) begin bad++; $display("FAIL waw_first got=bv%0b rd%0d mv%0b exp=bv1 rd8 mv0", br_valid, br_rd, mem_valid); end
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd8 || mem_payload !== 96'hE8 || br_valid !== 1'b0) begin bad++; $display("FAIL waw_second got=mv%0b rd%0d pl%0h bv%0b exp=mv1 rd8 plE8 bv0", mem_valid, mem_rd, mem_payload, br_valid); end
    // Writes to x0 never conflict, so this pair issues together.
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 96'hF0);
    set_slot(1, C_MEM, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 96'hF1);
    in_valid = 2'b11;
    tick(); clear_inputs();
    tick();
    total++; if (br_valid !== 1'b1 || br_payload !== 96'hF0 || mem_valid !== 1'b1 || mem_payload !== 96'hF1) begin bad++; $display("FAIL x0_pair got=bv%0b pl%0h mv%0b pl%0h exp=bv1 plF0 mv1 plF1", br_valid, br_payload, mem_valid, mem_payload); end
  endtask

  task automatic test_load_use;
    ex_load_valid = 1'b1; ex_load_rd = 5'd5;
    set_slot(0, C_ALU, 5'd5, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 96'h99);
    in_valid = 2'b01;
    tick(); clear_inputs();
    tick();
    total++; if (br_valid !== 1'b0 || mem_valid !== 1'b0 || occupancy !== 3'd1) begin bad++; $display("FAIL load_use_stall got=bv%0b mv%0b occ%0d exp=bv0 mv0 occ1", br_valid, mem_valid, occupancy); end
    tick();
    total++; if (br_valid !== 1'b0 || occupancy !== 3'd1) begin bad++; $display("FAIL load_use_stall2 got=bv%0b occ%0d exp=bv0 occ1", br_valid, occupancy); end
    ex_load_valid = 1'b0;
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd9 || occupancy !== 3'd0) begin bad++; $display("FAIL load_use_release got=bv%0b rd%0d occ%0d exp=bv1 rd9 occ0", br_valid, br_rd, occupancy); end
    // A load targeting x0 never stalls.
    ex_load_valid = 1'b1; ex_load_rd = 5'd0;
    set_slot(0, C_ALU, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 96'hA10);
    in_valid = 2'b01;
    tick(); clear_inputs();
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd10) begin bad++; $display("FAIL load_x0 got=bv%0b rd%0d exp=bv1 rd10", br_valid, br_rd); end
    ex_load_valid = 1'b0;
  endtask

  task automatic test_branch_alu;
    set_slot(0, C_BR,  5'd1, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 96'hB0);
    set_slot(1, C_ALU, 5'd2, 5'd3, 5'd11, 1'b1, 1'b1, 1'b1, 96'hB1);
    in_valid = 2'b11;
    tick(); clear_inputs();
    tick();
    total++; if (br_valid !== 1'b1 || br_payload !== 96'hB0 || mem_valid !== 1'b0 || occupancy !== 3'd1) begin bad++; $display("FAIL br_alone got=bv%0b pl%0h mv%0b occ%0d exp=bv1 plB0 mv0 occ1", br_valid, br_payload, mem_valid, occupancy); end
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd11 || br_payload !== 96'hB1 || mem_valid !== 1'b0) begin bad++; $display("FAIL alu_after_br got=bv%0b rd%0d pl%0h mv%0b exp=bv1 rd11 plB1 mv0", br_valid, br_rd, br_payload, mem_valid); end
  endtask

  task automatic test_mem_mem;
    set_slot(0, C_MEM, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 96'h120);
    set_slot(1, C_MEM, 5'd2, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 96'h130);
    in_valid = 2'b11;
    tick(); clear_inputs();
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd12 || br_valid !== 1'b0 || occupancy !== 3'd1) begin bad++; $display("FAIL mem_first got=mv%0b rd%0d bv%0b occ%0d exp=mv1 rd12 bv0 occ1", mem_valid, mem_rd, br_valid, occupancy); end
    tick();
    total++; if (mem_valid !== 1'b1 || mem_rd !== 5'd13 || mem_payload !== 96'h130 || br_valid !== 1'b0) begin bad++; $display("FAIL mem_second got=mv%0b rd%0d pl%0h bv%0b exp=mv1 rd13 pl130 bv0", mem_valid, mem_rd, mem_payload, br_valid); end
    tick();
    total++; if (mem_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL mem_idle got=mv%0b occ%0d exp=mv0 occ0", mem_valid, occupancy); end
  endtask

  task automatic test_back_to_back;
    // Tail sits at 2 here, so the second pair wraps to entries 0 and 1.
    out_ready = 1'b0;
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b1, 96'h140);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 96'h150);
    in_valid = 2'b11;
    tick();
    total++; if (occupancy !== 3'd2 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_first got=occ%0d rdy%0b exp=occ2 rdy1", occupancy, in_ready); end
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd16, 1'b1, 1'b1, 1'b1, 96'h160);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd17, 1'b1, 1'b0, 1'b1, 96'h170);
    tick();
    total++; if (occupancy !== 3'd4 || in_ready !== 1'b0 || stall_dec !== 1'b1) begin bad++; $display("FAIL b2b_full got=occ%0d rdy%0b stall%0b exp=occ4 rdy0 stall1", occupancy, in_ready, stall_dec); end
    total++; if (br_valid !== 1'b0 || mem_valid !== 1'b0 || br_payload !== 96'hB1) begin bad++; $display("FAIL b2b_frozen got=bv%0b mv%0b pl%0h exp=bv0 mv0 plB1", br_valid, mem_valid, br_payload); end
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd18, 1'b1, 1'b1, 1'b1, 96'h180);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd19, 1'b1, 1'b0, 1'b1, 96'h190);
    tick(); clear_inputs();
    total++; if (occupancy !== 3'd4 || br_valid !== 1'b0) begin bad++; $display("FAIL b2b_dropped got=occ%0d bv%0b exp=occ4 bv0", occupancy, br_valid); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_no_credit in_ready got=%0b exp=0", in_ready); end
    tick();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd14 || mem_valid !== 1'b1 || mem_rd !== 5'd15) begin bad++; $display("FAIL b2b_drainA got=bv%0b rd%0d mv%0b rd%0d exp=1 14 1 15", br_valid, br_rd, mem_valid, mem_rd); end
    total++; if (occupancy !== 3'd2 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_drainA_occ got=occ%0d rdy%0b exp=occ2 rdy1", occupancy, in_ready); end
    tick();
    total++; if (br_rd !== 5'd16 || br_payload !== 96'h160 || mem_rd !== 5'd17 || mem_payload !== 96'h170 || occupancy !== 3'd0) begin bad++; $display("FAIL b2b_drainB got=rd%0d pl%0h rd%0d pl%0h occ%0d exp=16 160 17 170 0", br_rd, br_payload, mem_rd, mem_payload, occupancy); end
    tick();
    total++; if (br_valid !== 1'b0 || mem_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL b2b_empty got=bv%0b mv%0b occ%0d exp=0 0 0", br_valid, mem_valid, occupancy); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 1'b1, 96'h200);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd21, 1'b1, 1'b0, 1'b1, 96'h210);
    in_valid = 2'b11;
    tick(); clear_inputs();
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd22, 1'b1, 1'b1, 1'b1, 96'h220);
    in_valid = 2'b01;
    tick(); clear_inputs();
    total++; if (occupancy !== 3'd3 || in_ready !== 1'b0) begin bad++; $display("FAIL flush_setup got=occ%0d rdy%0b exp=occ3 rdy0", occupancy, in_ready); end
    flush = 1'b1; out_ready = 1'b1;
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd25, 1'b1, 1'b1, 1'b1, 96'h250);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd26, 1'b1, 1'b0, 1'b1, 96'h260);
    in_valid = 2'b11;
    tick(); flush = 1'b0; clear_inputs();
    total++; if (occupancy !== 3'd0 || br_valid !== 1'b0 || mem_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush got=occ%0d bv%0b mv%0b rdy%0b exp=occ0 bv0 mv0 rdy1", occupancy, br_valid, mem_valid, in_ready); end
    tick();
    total++; if (occupancy !== 3'd0 || br_valid !== 1'b0 || mem_valid !== 1'b0) begin bad++; $display("FAIL flush_after got=occ%0d bv%0b mv%0b exp=0 0 0", occupancy, br_valid, mem_valid); end
  endtask

  task automatic test_reset_mid;
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd23, 1'b1, 1'b1, 1'b1, 96'h230);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd24, 1'b1, 1'b0, 1'b1, 96'h240);
    in_valid = 2'b11;
    tick();
    set_slot(0, C_ALU, 5'd1, 5'd2, 5'd27, 1'b1, 1'b1, 1'b1, 96'h270);
    set_slot(1, C_MEM, 5'd3, 5'd0, 5'd28, 1'b1, 1'b0, 1'b1, 96'h280);
    tick(); clear_inputs();
    total++; if (br_valid !== 1'b1 || br_rd !== 5'd23 || occupancy !== 3'd2) begin bad++; $display("FAIL midrst_setup got=bv%0b rd%0d occ%0d exp=bv1 rd23 occ2", br_valid, br_rd, occupancy); end
    rst = 1'b0;
    tick();
    total++; if (br_valid !== 1'b0 || mem_valid !== 1'b0 || br_we !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL midrst valid_we got=%0b%0b%0b%0b exp=0000", br_valid, mem_valid, br_we, mem_we); end
    total++; if (br_rd !== 5'd0 || mem_rd !== 5'd0 || br_payload !== '0 || mem_payload !== '0) begin bad++; $display("FAIL midrst rd_pl got=%0d %0d %0h %0h exp=0", br_rd, mem_rd, br_payload, mem_payload); end
    total++; if (occupancy !== 3'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL midrst occ_rdy got=occ%0d rdy%0b exp=occ0 rdy0", occupancy, in_ready); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release in_ready got=%0b exp=1", in_ready); end
    tick();
    total++; if (br_valid !== 1'b0 || mem_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL midrst_empty got=bv%0b mv%0b occ%0d exp=0 0 0", br_valid, mem_valid, occupancy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_waw();
    test_load_use();
    test_branch_alu();
    test_mem_mem();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
